cve2_rvfi_trace_fifo: RTL and testbench

CVE2_RVFI_TRACE_FIFO -- requirements
Module: cve2_rvfi_trace_fifo

---
 rtl/cve2_rvfi_trace_fifo.sv | 132 +++++++++++++
 tb/tb_cve2_rvfi_trace_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cve2_rvfi_trace_fifo.sv
// Captures RVFI retirement records into a small FIFO and presents them to a
// trace sink with a valid/ready handshake. Records that arrive while the FIFO
// is full are dropped and counted; the next accepted record is marked lost.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   trace_en_i               capture enable (drain continues when low)
//   rvfi_*                   retirement record inputs
//   trace_valid_o/ready_i    head-record handshake
//   trace_*_o                head record fields, flags = {lost, intr, trap}
//   fill_o                   number of stored records
//   drop_cnt_o, drop_clr_i   saturating drop counter and its sync clear
module cve2_rvfi_trace_fifo #(
  parameter int unsigned Depth        = 8,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trace_en_i,
  input  logic                      rvfi_valid,
  input  logic [31:0]               rvfi_pc_rdata,
  input  logic [31:0]               rvfi_insn,
  input  logic [4:0]                rvfi_rd_addr,
  input  logic [31:0]               rvfi_rd_wdata,
  input  logic                      rvfi_trap,
  input  logic                      rvfi_intr,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [31:0]               trace_pc_o,
  output logic [31:0]               trace_insn_o,
  output logic [31:0]               trace_rd_wdata_o,
  output logic [4:0]                trace_rd_addr_o,
  output logic [2:0]                trace_flags_o,
  output logic [$clog2(Depth):0]    fill_o,
  output logic [DropCntWidth-1:0]   drop_cnt_o,
  input  logic                      drop_clr_i
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned FillW = PtrW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [2:0]  flags;
  } rec_t;

  rec_t              mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]  fill_q;
  logic              lost_q;
  logic [DropCntWidth-1:0] drop_cnt_q;

  logic full_c, push_req_c, pop_c, push_c, drop_c;
  rec_t wr_rec_c;
  rec_t head_c;

  // Handshake qualification; a full FIFO still accepts when the head leaves.
  always_comb begin
    full_c     = (fill_q == FillW'(Depth));
    push_req_c = rvfi_valid & trace_en_i;
    pop_c      = (fill_q != '0) & trace_ready_i;
    push_c     = push_req_c & (~full_c | pop_c);
    drop_c     = push_req_c & full_c & ~pop_c;
  end

  // Incoming record; lost marks the first record after one or more drops.
  always_comb begin
    wr_rec_c          = '0;
    wr_rec_c.pc       = rvfi_pc_rdata;
    wr_rec_c.insn     = rvfi_insn;
    wr_rec_c.rd_addr  = rvfi_rd_addr;
    wr_rec_c.rd_wdata = rvfi_rd_wdata;
    wr_rec_c.flags    = {lost_q, rvfi_intr, rvfi_trap};
  end

  // Storage is not reset; contents are only observed while valid.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_rec_c;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two Depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_c && !pop_c) begin
        fill_q <= fill_q + FillW'(1);
      end else if (pop_c && !push_c) begin
        fill_q <= fill_q - FillW'(1);
      end
    end
  end

  // Drop tracking; a clear coinciding with a drop leaves a count of one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop_c) begin
        lost_q <= 1'b1;
      end else if (push_c) begin
        lost_q <= 1'b0;
      end
      if (drop_clr_i) begin
        drop_cnt_q <= drop_c ? DropCntWidth'(1) : '0;
      end else if (drop_c && !(&drop_cnt_q)) begin
        drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
      end
    end
  end

  assign head_c           = mem_q[rd_ptr_q];
  assign trace_valid_o    = (fill_q != '0);
  assign trace_pc_o       = head_c.pc;
  assign trace_insn_o     = head_c.insn;
  assign trace_rd_addr_o  = head_c.rd_addr;
  assign trace_rd_wdata_o = head_c.rd_wdata;
  assign trace_flags_o    = head_c.flags;
  assign fill_o           = fill_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_fifo.sv
// Scoreboard bench for cve2_rvfi_trace_fifo: the driver pushes expected
// records into a queue, a negedge monitor compares the presented head.
module tb_cve2_rvfi_trace_fifo;

  localparam int DEPTH = 8;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [2:0]  flags;
  } rec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic trace_en_i = 1'b0, rvfi_valid = 1'b0, rvfi_trap = 1'b0, rvfi_intr = 1'b0;
  logic [31:0] rvfi_pc_rdata = '0, rvfi_insn = '0, rvfi_rd_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic trace_ready_i = 1'b0, drop_clr_i = 1'b0;
  logic trace_valid_o;
  logic [31:0] trace_pc_o, trace_insn_o, trace_rd_wdata_o;
  logic [4:0]  trace_rd_addr_o;
  logic [2:0]  trace_flags_o;
  logic [3:0]  fill_o;
  logic [DCW-1:0] drop_cnt_o;

  cve2_rvfi_trace_fifo #(.Depth(DEPTH), .DropCntWidth(DCW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .trace_en_i(trace_en_i),
    .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
    .trace_rd_wdata_o(trace_rd_wdata_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_flags_o(trace_flags_o), .fill_o(fill_o),
    .drop_cnt_o(drop_cnt_o), .drop_clr_i(drop_clr_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  rec_t exp_q[$];
  int m_fill = 0;
  int m_drop = 0;
  bit m_lost = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check_int("fill", int'(fill_o), m_fill);
    check_int("drop_cnt", int'(drop_cnt_o), m_drop);
    check_int("valid", int'(trace_valid_o), (m_fill != 0) ? 1 : 0);
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] insn,
                              input logic [4:0] rd, input logic [31:0] wd,
                              input logic trap, input logic intr);
    rec_t r;
    r.pc = pc; r.insn = insn; r.rd = rd; r.wd = wd;
    r.flags = {1'b0, intr, trap};
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    return mk($urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  // One clock: check state reached at the last edge, then apply inputs for
  // the next edge and advance the reference model by that edge.
  task automatic step(input bit v, input bit en, input bit rdy, input bit clr,
                      input rec_t r);
    bit pop, req, push, drop;
    rec_t e;
    @(posedge clk); #1;
    check_state();
    rvfi_valid = v; trace_en_i = en; trace_ready_i = rdy; drop_clr_i = clr;
    rvfi_pc_rdata = r.pc; rvfi_insn = r.insn; rvfi_rd_addr = r.rd;
    rvfi_rd_wdata = r.wd; rvfi_trap = r.flags[0]; rvfi_intr = r.flags[1];
    pop  = (m_fill > 0) && rdy;
    req  = v && en;
    push = req && ((m_fill < DEPTH) || pop);
    drop = req && !push;
    if (push) begin
      e = r;
      e.flags[2] = m_lost;
      exp_q.push_back(e);
      m_lost = 1'b0;
    end
    if (drop) m_lost = 1'b1;
    if (clr) m_drop = drop ? 1 : 0;
    else if (drop && m_drop < DMAX) m_drop++;
    m_fill = m_fill + (push ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy, 1'b0, '0);
  endtask

  // Monitor: every presented head must match the oldest outstanding record.
  always @(negedge clk) begin
    rec_t act;
    if (rst_ni && trace_valid_o) begin
      act = {trace_pc_o, trace_insn_o, trace_rd_addr_o, trace_rd_wdata_o, trace_flags_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL head_unexpected actual=%h required=none", act);
      end else begin
        if (act !== exp_q[0]) begin
          bad++;
          $display("FAIL head_record actual=%h required=%h", act, exp_q[0]);
        end
        if (trace_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1;
    check_state();
    #11 rst_ni = 1'b1;

    // Single retire drains immediately.
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h0000_0080, 32'h0010_0093, 5'd1, 32'd1, 1'b0, 1'b0));
    idle(1'b1, 3);

    // Overflow: 10 retires into 8 slots, then drain; then lost marking.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h1000 + 32'(i * 4), 32'(i), 5'(i), 32'(i), 1'b0, 1'b0));
    idle(1'b0, 1);
    idle(1'b1, 8);
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h2000, 32'h13, 5'd2, 32'd7, 1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h2004, 32'h13, 5'd3, 32'd8, 1'b1, 1'b0));
    idle(1'b1, 3);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h3000 + 32'(i * 4), 32'(i), 5'(i), 32'(i), 1'b0, 1'b1));
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h3100, 32'h77, 5'd9, 32'h99, 1'b1, 1'b1));
    idle(1'b1, 10);

    // Capture disabled, saturation, clear colliding with a drop.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rnd_rec());
    for (int i = 0; i < DEPTH + DMAX + 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rnd_rec());
    step(1'b1, 1'b1, 1'b0, 1'b1, rnd_rec());
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(1'b1, 10);

    // Asynchronous reset with five records stored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rnd_rec());
    idle(1'b0, 1);
    @(posedge clk); #1;
    check_state();
    rvfi_valid = 1'b0; trace_ready_i = 1'b0; drop_clr_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    exp_q.delete();
    m_fill = 0; m_drop = 0; m_lost = 1'b0;
    check_state();
    check_int("flags_after_reset_lost", int'(dut.lost_q), 0);
    @(posedge clk); @(posedge clk); #4 rst_ni = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, rnd_rec());
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9,
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0, rnd_rec());

    idle(1'b1, DEPTH + 4);
    @(posedge clk); #1;
    check_state();
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
